// File: rtl/mult_shift_add_seq.sv
// Sequential shift-and-add multiplier with an integrated controller.
// One partial-product step per cycle; stops early once the remaining
// multiplier bits are all zero. Signed mode works on magnitudes and
// negates the result at the end.
module mult_shift_add_seq #(
    parameter int unsigned WIDTH = 3,
    localparam int unsigned CW   = $clog2(WIDTH + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               sgn,
    input  logic [WIDTH-1:0]   m,
    input  logic [WIDTH-1:0]   M,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] R,
    output logic [CW-1:0]      CountOut
);

    typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

    state_e             r_state;
    logic [WIDTH-1:0]   r_mreg;
    logic [2*WIDTH-1:0] r_mcand;
    logic [2*WIDTH-1:0] r_acc;
    logic               r_neg;
    logic               r_done;
    logic [2*WIDTH-1:0] r_R;
    logic [CW-1:0]      r_count;

    logic [WIDTH-1:0]   w_m_abs;
    logic [WIDTH-1:0]   w_M_abs;
    logic [2*WIDTH-1:0] w_addend;

    // Operand magnitudes; -(-2^(W-1)) wraps to 2^(W-1), which is the correct unsigned magnitude.
    always_comb begin
        w_m_abs  = (sgn && m[WIDTH-1]) ? (~m + 1'b1) : m;
        w_M_abs  = (sgn && M[WIDTH-1]) ? (~M + 1'b1) : M;
        w_addend = r_mreg[0] ? r_mcand : '0;
    end

    // Controller and datapath; every output except busy is registered here.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= StIdle;
            r_mreg  <= '0;
            r_mcand <= '0;
            r_acc   <= '0;
            r_neg   <= 1'b0;
            r_done  <= 1'b0;
            r_R     <= '0;
            r_count <= '0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (start) begin
                        r_mreg  <= w_m_abs;
                        r_mcand <= {{WIDTH{1'b0}}, w_M_abs};
                        r_neg   <= sgn & (m[WIDTH-1] ^ M[WIDTH-1]);
                        r_acc   <= '0;
                        r_count <= '0;
                        r_state <= StCalc;
                    end
                end
                StCalc: begin
                    if (r_mreg == '0) begin
                        r_state <= StFix;
                    end else begin
                        r_acc   <= r_acc + w_addend;
                        r_mcand <= r_mcand << 1;
                        r_mreg  <= r_mreg >> 1;
                        r_count <= r_count + CW'(1);
                    end
                end
                StFix: begin
                    r_R     <= r_neg ? (~r_acc + 1'b1) : r_acc;
                    r_done  <= 1'b1;
                    r_state <= StDone;
                end
                StDone: begin
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    // busy is a plain decode of the state register.
    always_comb begin
        busy     = (r_state != StIdle);
        done     = r_done;
        R        = r_R;
        CountOut = r_count;
    end

endmodule

// File: tb/tb_mult_shift_add_seq.sv
// Self-checking bench for mult_shift_add_seq at WIDTH=3 and WIDTH=8.
module tb_mult_shift_add_seq;

    typedef struct {
        logic [15:0] r;
        int          cnt;
        int          lat;
    } exp_t;

    logic        clk;
    logic        rst_n;

    logic        start3, sgn3, busy3, done3;
    logic [2:0]  m3, mc3;
    logic [5:0]  r3;
    logic [1:0]  cnt3;

    logic        start8, sgn8, busy8, done8;
    logic [7:0]  m8, mc8;
    logic [15:0] r8;
    logic [3:0]  cnt8;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    mult_shift_add_seq #(.WIDTH(3)) dut3 (
        .clk      (clk),
        .reset    (rst_n),
        .start    (start3),
        .sgn      (sgn3),
        .m        (m3),
        .M        (mc3),
        .busy     (busy3),
        .done     (done3),
        .R        (r3),
        .CountOut (cnt3)
    );

    mult_shift_add_seq #(.WIDTH(8)) dut8 (
        .clk      (clk),
        .reset    (rst_n),
        .start    (start8),
        .sgn      (sgn8),
        .m        (m8),
        .M        (mc8),
        .busy     (busy8),
        .done     (done8),
        .R        (r8),
        .CountOut (cnt8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: signed/unsigned product mod 2^(2w), iterations and done cycle.
    function automatic exp_t model(input int w, input bit s, input longint a_in, input longint b_in);
        exp_t   e;
        longint a, b, am, p;
        int     k;
        a = a_in;
        b = b_in;
        if (s && ((a >> (w - 1)) & 1) == 1) a = a - (longint'(1) << w);
        if (s && ((b >> (w - 1)) & 1) == 1) b = b - (longint'(1) << w);
        p  = (a * b) & ((longint'(1) << (2 * w)) - 1);
        am = (a < 0) ? -a : a;
        k  = 0;
        while ((am >> k) != 0) k++;
        e.r   = 16'(p);
        e.cnt = k;
        e.lat = k + 3;
        return e;
    endfunction

    // Issue a start on the WIDTH=3 DUT; returns after the accepting edge E0.
    task automatic drive3(input bit s, input logic [2:0] a, input logic [2:0] b);
        @(negedge clk);
        start3 = 1'b1;
        sgn3   = s;
        m3     = a;
        mc3    = b;
        sb.push_back(model(3, s, longint'(a), longint'(b)));
        @(posedge clk);
        #1 start3 = 1'b0;
    endtask

    // Wait (bounded) for done on the WIDTH=3 DUT; cycle 1 is the first negedge after E0.
    task automatic wait3(output int cyc, output bit seen, output int busy_cyc);
        cyc = 0;
        seen = 1'b0;
        busy_cyc = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            cyc++;
            if (busy3) busy_cyc++;
            if (done3) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        start3 = 1'b0; sgn3 = 1'b0; m3 = '0; mc3 = '0;
        start8 = 1'b0; sgn8 = 1'b0; m8 = '0; mc8 = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if ({r3, cnt3, busy3, done3} !== 10'b0) begin
            miscompares++;
            $display("FAIL reset_state: R=%h cnt=%0d busy=%b done=%b, required all 0",
                     r3, cnt3, busy3, done3);
        end
    endtask

    task automatic test_unsigned;
        logic [2:0] ta[2] = '{3'b001, 3'd7};
        logic [2:0] tb[2] = '{3'b100, 3'd7};
        int cyc, bc;
        bit seen;
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            drive3(1'b0, ta[i], tb[i]);
            wait3(cyc, seen, bc);
            e = sb.pop_front();
            vectors++;
            if (!seen || cyc != e.lat || {10'b0, r3} !== e.r || int'(cnt3) != e.cnt) begin
                miscompares++;
                $display("FAIL unsigned_%0d: seen=%b cyc=%0d R=%0d cnt=%0d, required cyc=%0d R=%0d cnt=%0d",
                         i, seen, cyc, r3, cnt3, e.lat, e.r, e.cnt);
            end
            vectors++;
            if (bc != e.lat) begin
                miscompares++;
                $display("FAIL busy_len_%0d: busy %0d cycles, required %0d", i, bc, e.lat);
            end
        end
    endtask

    task automatic test_zero;
        int cyc, bc;
        bit seen;
        exp_t e;
        logic [5:0] prev;
        prev = r3;
        drive3(1'b0, 3'd0, 3'd5);
        @(negedge clk);
        vectors++;
        if (r3 !== prev || !busy3) begin
            miscompares++;
            $display("FAIL zero_hold: R=%0d busy=%b, required R=%0d busy=1", r3, busy3, prev);
        end
        wait3(cyc, seen, bc);
        cyc = cyc + 1;
        e = sb.pop_front();
        vectors++;
        if (!seen || cyc != e.lat || {10'b0, r3} !== e.r || int'(cnt3) != e.cnt) begin
            miscompares++;
            $display("FAIL zero_mult: seen=%b cyc=%0d R=%0d cnt=%0d, required cyc=%0d R=%0d cnt=%0d",
                     seen, cyc, r3, cnt3, e.lat, e.r, e.cnt);
        end
    endtask

    task automatic test_signed;
        logic [2:0] ta[4] = '{3'b100, 3'd3, 3'b111, 3'b100};
        logic [2:0] tb[4] = '{3'b100, 3'b110, 3'd3, 3'd3};
        int cyc, bc;
        bit seen;
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            drive3(1'b1, ta[i], tb[i]);
            wait3(cyc, seen, bc);
            e = sb.pop_front();
            vectors++;
            if (!seen || cyc != e.lat || {10'b0, r3} !== e.r || int'(cnt3) != e.cnt) begin
                miscompares++;
                $display("FAIL signed_%0d: seen=%b cyc=%0d R=%b cnt=%0d, required cyc=%0d R=%b cnt=%0d",
                         i, seen, cyc, r3, cnt3, e.lat, e.r[5:0], e.cnt);
            end
        end
    endtask

    task automatic test_restart_ignored;
        int dones;
        exp_t e;
        drive3(1'b0, 3'd7, 3'd7);
        @(negedge clk);
        start3 = 1'b1; sgn3 = 1'b1; m3 = 3'd1; mc3 = 3'd1;
        @(negedge clk);
        start3 = 1'b0;
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done3) dones++;
        end
        e = sb.pop_front();
        vectors++;
        if (dones != 1 || {10'b0, r3} !== e.r || int'(cnt3) != e.cnt) begin
            miscompares++;
            $display("FAIL restart_ignored: dones=%0d R=%0d cnt=%0d, required dones=1 R=%0d cnt=%0d",
                     dones, r3, cnt3, e.r, e.cnt);
        end
    endtask

    task automatic test_reset_abort;
        int dones, cyc, bc;
        bit seen;
        exp_t e;
        drive3(1'b0, 3'd7, 3'd5);
        void'(sb.pop_front());
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        vectors++;
        if (r3 !== 6'd0 || cnt3 !== 2'd0 || busy3 !== 1'b0 || done3 !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_state: R=%0d cnt=%0d busy=%b done=%b, required all 0",
                     r3, cnt3, busy3, done3);
        end
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done3) dones++;
        end
        vectors++;
        if (dones != 0) begin
            miscompares++;
            $display("FAIL abort_no_done: %0d done pulses, required 0", dones);
        end
        drive3(1'b0, 3'd6, 3'd5);
        wait3(cyc, seen, bc);
        e = sb.pop_front();
        vectors++;
        if (!seen || cyc != e.lat || {10'b0, r3} !== e.r || int'(cnt3) != e.cnt) begin
            miscompares++;
            $display("FAIL after_abort: seen=%b cyc=%0d R=%0d cnt=%0d, required cyc=%0d R=%0d cnt=%0d",
                     seen, cyc, r3, cnt3, e.lat, e.r, e.cnt);
        end
    endtask

    task automatic test_back_to_back;
        int cyc, bc;
        bit seen;
        exp_t e;
        logic [2:0] a, b;
        bit s;
        for (int i = 0; i < 10; i++) begin
            a = 3'($urandom_range(0, 7));
            b = 3'($urandom_range(0, 7));
            s = 1'($urandom_range(0, 1));
            drive3(s, a, b);
            wait3(cyc, seen, bc);
            e = sb.pop_front();
            vectors++;
            if (!seen || cyc != e.lat || {10'b0, r3} !== e.r || int'(cnt3) != e.cnt) begin
                miscompares++;
                $display("FAIL b2b_%0d s=%b m=%0d M=%0d: seen=%b cyc=%0d R=%b cnt=%0d, required cyc=%0d R=%b cnt=%0d",
                         i, s, a, b, seen, cyc, r3, cnt3, e.lat, e.r[5:0], e.cnt);
            end
        end
    endtask

    task automatic test_wide;
        logic [7:0] ta[3] = '{8'd255, 8'h80, 8'd13};
        logic [7:0] tb[3] = '{8'd255, 8'h80, 8'hF6};
        bit         ts[3] = '{1'b0, 1'b1, 1'b1};
        int   cyc;
        bit   seen;
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            start8 = 1'b1; sgn8 = ts[i]; m8 = ta[i]; mc8 = tb[i];
            sb.push_back(model(8, ts[i], longint'(ta[i]), longint'(tb[i])));
            @(posedge clk);
            #1 start8 = 1'b0;
            cyc = 0;
            seen = 1'b0;
            for (int j = 0; j < 30; j++) begin
                @(negedge clk);
                cyc++;
                if (done8) begin
                    seen = 1'b1;
                    break;
                end
            end
            e = sb.pop_front();
            vectors++;
            if (!seen || cyc != e.lat || r8 !== e.r || int'(cnt8) != e.cnt) begin
                miscompares++;
                $display("FAIL wide_%0d: seen=%b cyc=%0d R=%0d cnt=%0d, required cyc=%0d R=%0d cnt=%0d",
                         i, seen, cyc, r8, cnt8, e.lat, e.r, e.cnt);
            end
        end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_zero();
        test_signed();
        test_restart_ignored();
        test_reset_abort();
        test_back_to_back();
        test_wide();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mult_shift_add_seq.md
Name: mult_shift_add_seq

Overview:
- Parametrised sequential shift-and-add multiplier with an integrated controller. It succeeds the fixed 3-bit datapath-plus-external-control multiplier.
- Internal FSM replaces the externally driven select and enable strobes. Adds a start/busy/done handshake, a WIDTH parameter, a per-operation signed mode and early termination once the remaining multiplier bits are zero.
- Sits in the arithmetic datapath as a drop-in iterative multiplier for the course designs.

Parameters:
- WIDTH, 3, operand width in bits (≥2). Product width is 2*WIDTH.
- CW, $clog2(WIDTH+1), iteration-counter width (derived, not overridden).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- sgn  in  1  1 = operands are two's complement, 0 = unsigned; sampled with start.
- m  in  WIDTH  multiplier; sampled with start.
- M  in  WIDTH  multiplicand; sampled with start.
- busy  out  1  high whenever state ≠ IDLE.
- done  out  1  one-cycle pulse; R valid.
- R  out  2*WIDTH  product; held until the next accepted start.
- CountOut  out  CW  iterations performed by the last or current operation.

Behaviour:
- Reset: reset==0 at a clk edge forces IDLE, R=0, CountOut=0, done=0, busy=0 and clears all internal registers. Applies in any state; an aborted operation produces no done.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - start=1 at edge E0 → CALC.
  - mreg ← |m| and mcand ← |M|, zero-extended to 2W.
    - Absolute value is taken only when sgn=1. For the most negative value, |−2^(W−1)| = 2^(W−1) and still fits W unsigned bits.
  - neg ← sgn & (m[W−1]^M[W−1]); acc ← 0; CountOut ← 0.
  - R keeps its old value until FIX.
- CALC, one step per cycle:
  - If mreg==0 → FIX, no datapath change.
  - Else: acc ← acc + (mreg[0] ? mcand : 0); mcand ← mcand<<1; mreg ← mreg>>1; CountOut ← CountOut+1.
  - mreg is exhausted after at most WIDTH steps, so CountOut ≤ WIDTH. No separate count-limit state is needed.
- FIX: R ← neg ? −acc : acc, computed mod 2^(2W); → DONE.
- DONE: done=1 for exactly this cycle; → IDLE. start is ignored here.
- Latency: k = index of the highest set bit of |m| plus 1 (k=0 for m=0).
  - CALC occupies k+1 cycles.
  - done is high in cycle k+3 after E0 (E0 edge is cycle 0).
  - start→done worst case is WIDTH+3 cycles.
  - Back-to-back: the next start is accepted in the IDLE cycle following DONE.
- start while busy: ignored. Operands and sgn changing while busy: no effect.
- Widths: acc and mcand are 2W bits. The unsigned max (2^W−1)^2 and signed (−2^(W−1))^2 both fit, so no overflow occurs.
- sgn=0: m and M are treated as plain unsigned and neg=0.
- Outputs are registered except busy (decode of the state register).

Test Plan:
- WIDTH=3, sgn=0, m=3'b001, M=3'b100, start pulse → R=6'd4, CountOut=1, done high 4 cycles after the start edge, busy high for 4 cycles.
- WIDTH=3, sgn=0, m=7, M=7 → R=6'd49, CountOut=3, done at cycle 6.
- m=0, M=5 → R=0, CountOut=0, done at cycle 3. Previous R stays held until the FIX edge.
- WIDTH=3, sgn=1:
  - m=−4, M=−4 → R=6'd16.
  - m=3, M=−2 → R=6'b111010 (−6).
  - m=−1, M=3 → R=6'b111101 (−3).
- Start is re-pulsed during CALC with different operands → ignored. Result equals the first operation, and exactly one done pulse is produced.
- reset=0 for one cycle mid-CALC → next cycle R=0, CountOut=0, busy=0, no done. A fresh start then completes normally. At WIDTH=8, 255×255 → R=16'd65025, CountOut=8.
